psum_wb_ctrl: RTL and testbench

- Parametrised successor of the psum store controller. Streams output partial sums from the PE array into the psum GLB over a valid/ready handshake and generates the GLB addresses.
- Adds a programmable base address, runtime layer sizes, and an accumulate mode that does read-modify-write against GLB contents.
- Sits between the PE-array psum output and the psum GLB port. It is driven by the top-level pass sequencer.

---
 rtl/psum_wb_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_psum_wb_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_wb_ctrl.sv
`timescale 1ns/1ps
// psum_wb_ctrl: streams PE-array psums into the psum GLB (overwrite or read-modify-write).
// Optional macro PSUM_WB_SAT_EN makes the accumulate add saturate to the signed DW range.
module psum_wb_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int PW = 4,
    parameter int EW = 7,
    parameter int NW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [EW-1:0] i_layer_EF,
    input  logic [PW-1:0] i_layer_p,
    input  logic [NW-1:0] i_layer_n,
    input  logic [AW-1:0] i_base_addr,
    input  logic          i_acc_mode,
    input  logic          i_psum_valid,
    input  logic [DW-1:0] i_psum_data,
    output logic          o_psum_ready,
    output logic          o_glb_re,
    output logic [AW-1:0] o_glb_ra,
    input  logic [DW-1:0] i_glb_rdata,
    output logic          o_glb_we,
    output logic [AW-1:0] o_glb_wa,
    output logic [DW-1:0] o_glb_wd,
    output logic          o_iter_done,
    output logic          o_pass_done,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_RD,
        S_WR
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] ef_q, ef_d;
    logic [PW-1:0] p_q, p_d;
    logic [NW-1:0] n_q, n_d;
    logic [AW-1:0] base_q, base_d;
    logic          acc_q, acc_d;
    logic [PW-1:0] cnt_p_q, cnt_p_d;
    logic [EW-1:0] cnt_e_q, cnt_e_d;
    logic [EW-1:0] iter_q, iter_d;
    logic [NW-1:0] batch_q, batch_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic          pass_q, pass_d;
    logic          wr_q, wr_d;

    logic          accept;
    logic          hs;
    logic          p_wrap;
    logic          e_wrap;
    logic          i_wrap;
    logic          b_wrap;
    logic          last_psum;
    logic          in_wr;
    logic [AW-1:0] addr_calc;
    logic [DW-1:0] acc_sum;

    assign accept = (state_q == S_IDLE) & i_start
                  & (|i_layer_EF) & (|i_layer_p) & (|i_layer_n);
    assign hs     = (state_q == S_STREAM) & i_psum_valid;

    assign p_wrap    = cnt_p_q == p_q - PW'(1);
    assign e_wrap    = cnt_e_q == ef_q - EW'(1);
    assign i_wrap    = iter_q >= ef_q - EW'(1);
    assign b_wrap    = batch_q >= n_q - NW'(1);
    assign last_psum = p_wrap & e_wrap;

    // Layout: [batch][p][E][F], with iter_cnt selecting the F column.
    assign addr_calc = base_q
                     + ((AW'(batch_q) * AW'(p_q) + AW'(cnt_p_q)) * AW'(ef_q)
                        + AW'(cnt_e_q)) * AW'(ef_q)
                     + AW'(iter_q);

`ifdef PSUM_WB_SAT_EN
    logic [DW:0] sum_ext;

    always_comb begin
        sum_ext = {i_glb_rdata[DW-1], i_glb_rdata} + {data_q[DW-1], data_q};
        acc_sum = sum_ext[DW-1:0];
        if (sum_ext[DW] != sum_ext[DW-1]) begin
            acc_sum = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}}
                                  : {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign acc_sum = i_glb_rdata + data_q;
`endif

    always_comb begin
        state_d = state_q;
        ef_d    = ef_q;
        p_d     = p_q;
        n_d     = n_q;
        base_d  = base_q;
        acc_d   = acc_q;
        cnt_p_d = cnt_p_q;
        cnt_e_d = cnt_e_q;
        iter_d  = iter_q;
        batch_d = batch_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        pass_d  = pass_q;
        wr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_STREAM;
                    ef_d    = i_layer_EF;
                    p_d     = i_layer_p;
                    n_d     = i_layer_n;
                    base_d  = i_base_addr;
                    acc_d   = i_acc_mode;
                    cnt_p_d = '0;
                    cnt_e_d = '0;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    addr_d = addr_calc;
                    data_d = i_psum_data;
                    last_d = last_psum;
                    pass_d = last_psum & i_wrap & b_wrap;
                    wr_d   = ~acc_q;
                    if (p_wrap) begin
                        cnt_p_d = '0;
                        cnt_e_d = e_wrap ? '0 : cnt_e_q + EW'(1);
                    end else begin
                        cnt_p_d = cnt_p_q + PW'(1);
                    end
                    if (last_psum) begin
                        if (i_wrap) begin
                            iter_d  = '0;
                            batch_d = b_wrap ? '0 : batch_q + NW'(1);
                        end else begin
                            iter_d = iter_q + EW'(1);
                        end
                    end
                    if (acc_q) begin
                        state_d = S_RD;
                    end else if (last_psum) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                state_d = last_q ? S_IDLE : S_STREAM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ef_q    <= '0;
            p_q     <= '0;
            n_q     <= '0;
            base_q  <= '0;
            acc_q   <= 1'b0;
            cnt_p_q <= '0;
            cnt_e_q <= '0;
            iter_q  <= '0;
            batch_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            pass_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ef_q    <= ef_d;
            p_q     <= p_d;
            n_q     <= n_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            cnt_p_q <= cnt_p_d;
            cnt_e_q <= cnt_e_d;
            iter_q  <= iter_d;
            batch_q <= batch_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            pass_q  <= pass_d;
            wr_q    <= wr_d;
        end
    end

    // Overwrite writes come from the wr_q pipeline, accumulate writes from WR.
    assign in_wr        = state_q == S_WR;
    assign o_glb_we     = wr_q | in_wr;
    assign o_glb_wa     = o_glb_we ? addr_q : '0;
    assign o_glb_wd     = in_wr ? acc_sum : (wr_q ? data_q : '0);
    assign o_glb_re     = state_q == S_RD;
    assign o_glb_ra     = o_glb_re ? addr_q : '0;
    assign o_psum_ready = state_q == S_STREAM;
    assign o_iter_done  = o_glb_we & last_q;
    assign o_pass_done  = o_glb_we & pass_q;
    assign o_busy       = (state_q != S_IDLE) & ~o_iter_done;

endmodule

// File: tb/tb_psum_wb_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for psum_wb_ctrl: random psums and valid patterns
// against a formula-level address/GLB model.
module tb_psum_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  lef;
    logic [3:0]  lp;
    logic [2:0]  ln;
    logic [15:0] base;
    logic        acc;
    logic        pv;
    logic [15:0] pd;
    logic        rdy;
    logic        re;
    logic [15:0] ra;
    logic [15:0] rdata;
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        idone;
    logic        pdone;
    logic        busy;

    int total = 0;
    int bad = 0;
    int m_iter = 0;
    int m_batch = 0;
    logic [15:0] mem [65536];
    logic [15:0] seen_wa[$];
    logic [15:0] seen_wd[$];

    always #5 clk = ~clk;

    psum_wb_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_layer_EF  (lef),
        .i_layer_p   (lp),
        .i_layer_n   (ln),
        .i_base_addr (base),
        .i_acc_mode  (acc),
        .i_psum_valid(pv),
        .i_psum_data (pd),
        .o_psum_ready(rdy),
        .o_glb_re    (re),
        .o_glb_ra    (ra),
        .i_glb_rdata (rdata),
        .o_glb_we    (we),
        .o_glb_wa    (wa),
        .o_glb_wd    (wd),
        .o_iter_done (idone),
        .o_pass_done (pdone),
        .o_busy      (busy)
    );

    function automatic logic [15:0] model_addr(input logic [15:0] b,
        input int p, input int ef, input int bt, input int cp,
        input int ce, input int it);
        int lin;
        lin = ((bt * p + cp) * ef + ce) * ef + it;
        return b + 16'(lin);
    endfunction

    function automatic logic [15:0] model_acc(input logic [15:0] g,
                                              input logic [15:0] d);
        int s;
        s = int'($signed(g)) + int'($signed(d));
`ifdef PSUM_WB_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    // One iteration: start pulse, then p*EF psums; vmode 0=always,1=toggle,2=random.
    task automatic run_iter(input int ef, input int p, input int n,
        input logic [15:0] b, input logic am, input int vmode,
        input int fixd, input bit poke);
        int ntot, idx, cyc, nw;
        int rd_due[$];
        logic [15:0] rd_addr[$];
        logic [15:0] rd_data[$];
        int wr_due[$];
        logic [15:0] wr_addr[$];
        logic [15:0] wr_data[$];
        bit pass_end, ex_we, ex_re, ex_last, ex_rdy;
        logic [15:0] a, d;
        ntot = ef * p;
        idx = 0;
        cyc = 0;
        nw = 0;
        pass_end = (m_iter == ef - 1) && (m_batch == n - 1);
        @(negedge clk);
        lef = 7'(ef); lp = 4'(p); ln = 3'(n);
        base = b; acc = am; start = 1'b1; pv = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (nw < ntot && cyc < 1000) begin
            ex_we = wr_due.size() > 0 && wr_due[0] == cyc;
            ex_re = rd_due.size() > 0 && rd_due[0] == cyc;
            ex_last = ex_we && (nw == ntot - 1);
            ex_rdy = (idx < ntot) &&
                     !(am && (rd_due.size() > 0 || wr_due.size() > 0));
            total++;
            if (we !== ex_we) begin
                bad++;
                $display("FAIL we cyc=%0d got=%b exp=%b", cyc, we, ex_we);
            end
            total++;
            if (re !== ex_re) begin
                bad++;
                $display("FAIL re cyc=%0d got=%b exp=%b", cyc, re, ex_re);
            end
            total++;
            if (rdy !== ex_rdy) begin
                bad++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, rdy, ex_rdy);
            end
            total++;
            if (busy !== !ex_last) begin
                bad++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !ex_last);
            end
            total++;
            if (idone !== ex_last) begin
                bad++;
                $display("FAIL iter_done cyc=%0d got=%b exp=%b", cyc, idone, ex_last);
            end
            total++;
            if (pdone !== (ex_last && pass_end)) begin
                bad++;
                $display("FAIL pass_done cyc=%0d got=%b exp=%b",
                         cyc, pdone, ex_last && pass_end);
            end
            if (ex_we) begin
                a = wr_addr.pop_front();
                d = wr_data.pop_front();
                void'(wr_due.pop_front());
                total++;
                if (wa !== a) begin
                    bad++;
                    $display("FAIL wa cyc=%0d got=%h exp=%h", cyc, wa, a);
                end
                total++;
                if (wd !== d) begin
                    bad++;
                    $display("FAIL wd cyc=%0d got=%h exp=%h", cyc, wd, d);
                end
                seen_wa.push_back(wa);
                seen_wd.push_back(wd);
                mem[a] = d;
                nw++;
            end
            if (ex_re) begin
                a = rd_addr.pop_front();
                d = rd_data.pop_front();
                void'(rd_due.pop_front());
                total++;
                if (ra !== a) begin
                    bad++;
                    $display("FAIL ra cyc=%0d got=%h exp=%h", cyc, ra, a);
                end
                rdata = mem[a];
                wr_due.push_back(cyc + 1);
                wr_addr.push_back(a);
                wr_data.push_back(model_acc(mem[a], d));
            end else begin
                rdata = 16'($urandom);
            end
            start = poke && cyc == 2 && idx < ntot;
            if (start) begin
                base = 16'($urandom);
                lp = 4'($urandom);
            end
            if (idx < ntot) begin
                case (vmode)
                    0: pv = 1'b1;
                    1: pv = (cyc % 2) == 0;
                    default: pv = 1'($urandom_range(0, 1));
                endcase
            end else begin
                pv = 1'b0;
            end
            pd = (fixd >= 0) ? 16'(fixd) : 16'($urandom);
            if (pv && ex_rdy) begin
                a = model_addr(b, p, ef, m_batch, idx % p, idx / p, m_iter);
                if (am) begin
                    rd_due.push_back(cyc + 1);
                    rd_addr.push_back(a);
                    rd_data.push_back(pd);
                end else begin
                    wr_due.push_back(cyc + 1);
                    wr_addr.push_back(a);
                    wr_data.push_back(pd);
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pv = 1'b0;
        if (nw < ntot) begin
            total++;
            bad++;
            $display("FAIL timeout writes got=%0d exp=%0d", nw, ntot);
        end
        total++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after we=%b busy=%b exp 0 0", we, busy);
        end
        m_iter++;
        if (m_iter >= ef) begin
            m_iter = 0;
            m_batch++;
            if (m_batch >= n) m_batch = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({rdy, re, we, idone, pdone, busy} !== 6'b0 ||
            ra !== 16'h0 || wa !== 16'h0 || wd !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h/%h/%h exp 0",
                     {rdy, re, we, idone, pdone, busy}, ra, wa, wd);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rdy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b rdy=%b exp 0 0", busy, rdy);
        end
    endtask

    task automatic test_overwrite_basic;
        logic [15:0] ex [8];
        ex = '{16'h0100, 16'h0104, 16'h0102, 16'h0106,
               16'h0101, 16'h0105, 16'h0103, 16'h0107};
        seen_wa.delete();
        run_iter(2, 2, 1, 16'h0100, 1'b0, 0, -1, 1'b0);
        run_iter(2, 2, 1, 16'h0100, 1'b0, 0, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seen_wa.size() <= i || seen_wa[i] !== ex[i]) begin
                bad++;
                $display("FAIL ow_addr[%0d] got=%h exp=%h", i,
                         (seen_wa.size() > i) ? seen_wa[i] : 16'hxxxx, ex[i]);
            end
        end
    endtask

    task automatic test_accum_basic;
        mem[0] = 16'h0010;
        seen_wd.delete();
        run_iter(1, 1, 1, 16'h0000, 1'b1, 0, 5, 1'b0);
        total++;
        if (seen_wd.size() != 1 || seen_wd[0] !== 16'h0015) begin
            bad++;
            $display("FAIL acc_wd got=%h exp=0015",
                     (seen_wd.size() > 0) ? seen_wd[0] : 16'hxxxx);
        end
    endtask

    task automatic test_stall_toggle;
        logic [15:0] ex [8];
        ex = '{16'h0100, 16'h0104, 16'h0102, 16'h0106,
               16'h0101, 16'h0105, 16'h0103, 16'h0107};
        seen_wa.delete();
        run_iter(2, 2, 1, 16'h0100, 1'b0, 1, -1, 1'b0);
        run_iter(2, 2, 1, 16'h0100, 1'b0, 1, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seen_wa.size() <= i || seen_wa[i] !== ex[i]) begin
                bad++;
                $display("FAIL stall_addr[%0d] got=%h exp=%h", i,
                         (seen_wa.size() > i) ? seen_wa[i] : 16'hxxxx, ex[i]);
            end
        end
    endtask

    task automatic test_zero_busy_start;
        for (int z = 0; z < 3; z++) begin
            @(negedge clk);
            lef = (z == 0) ? 7'd0 : 7'd2;
            lp = (z == 1) ? 4'd0 : 4'd2;
            ln = (z == 2) ? 3'd0 : 3'd1;
            base = 16'h0200; acc = 1'b0; start = 1'b1; pv = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (busy !== 1'b0 || we !== 1'b0 || rdy !== 1'b0) begin
                    bad++;
                    $display("FAIL zero_start[%0d] busy=%b we=%b rdy=%b exp 0 0 0",
                             z, busy, we, rdy);
                end
                @(negedge clk);
            end
            pv = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            run_iter(2, 2, 2, 16'h0A00, 1'($urandom_range(0, 1)), 2, -1, 1'b1);
    endtask

    task automatic test_sat;
        logic [15:0] e1, e2;
`ifdef PSUM_WB_SAT_EN
        e1 = 16'h7FFF; e2 = 16'h8000;
`else
        e1 = 16'h8000; e2 = 16'h7FFF;
`endif
        mem[16'h0400] = 16'h7FFF;
        mem[16'h0401] = 16'h8000;
        seen_wd.delete();
        run_iter(1, 1, 1, 16'h0400, 1'b1, 0, 1, 1'b0);
        run_iter(1, 1, 1, 16'h0401, 1'b1, 0, 16'hFFFF, 1'b0);
        total++;
        if (seen_wd.size() < 1 || seen_wd[0] !== e1) begin
            bad++;
            $display("FAIL sat_pos got=%h exp=%h",
                     (seen_wd.size() > 0) ? seen_wd[0] : 16'hxxxx, e1);
        end
        total++;
        if (seen_wd.size() < 2 || seen_wd[1] !== e2) begin
            bad++;
            $display("FAIL sat_neg got=%h exp=%h",
                     (seen_wd.size() > 1) ? seen_wd[1] : 16'hxxxx, e2);
        end
    endtask

    task automatic test_reset_mid;
        int nw, cyc;
        nw = 0;
        cyc = 0;
        @(negedge clk);
        lef = 7'd2; lp = 4'd4; ln = 3'd1; base = 16'h0300;
        acc = 1'b0; start = 1'b1; pv = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pv = 1'b1;
        while (nw < 3 && cyc < 50) begin
            pd = 16'($urandom);
            @(negedge clk);
            if (we === 1'b1) nw++;
            cyc++;
        end
        total++;
        if (nw != 3) begin
            bad++;
            $display("FAIL mid_writes got=%0d exp=3", nw);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({rdy, re, we, idone, pdone, busy} !== 6'b0 ||
            ra !== 16'h0 || wa !== 16'h0 || wd !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%h/%h exp 0",
                     {rdy, re, we, idone, pdone, busy}, ra, wa, wd);
        end
        pv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_iter = 0;
        m_batch = 0;
        seen_wa.delete();
        run_iter(2, 4, 1, 16'h0300, 1'b0, 0, -1, 1'b0);
        run_iter(2, 4, 1, 16'h0300, 1'b0, 2, -1, 1'b0);
        total++;
        if (seen_wa.size() < 1 || seen_wa[0] !== 16'h0300) begin
            bad++;
            $display("FAIL restart_addr got=%h exp=0300",
                     (seen_wa.size() > 0) ? seen_wa[0] : 16'hxxxx);
        end
    endtask

    task automatic test_random;
        int ef, p, n;
        logic [15:0] b;
        for (int t = 0; t < 6; t++) begin
            ef = $urandom_range(1, 4);
            p = $urandom_range(1, 3);
            n = $urandom_range(1, 2);
            b = 16'($urandom);
            for (int i = 0; i < ef * n; i++)
                run_iter(ef, p, n, b, 1'($urandom_range(0, 1)), 2, -1, i == 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        rst = 1'b1; start = 1'b0; lef = '0; lp = '0; ln = '0;
        base = '0; acc = 1'b0; pv = 1'b0; pd = '0; rdata = '0;
        test_reset();
        test_overwrite_basic();
        test_accum_basic();
        test_stall_toggle();
        test_zero_busy_start();
        test_sat();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
